// File: rtl/enable_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : enable_rr_arbiter
// Brief   : Round-robin arbiter sharing one enable resource among N requesters.
// Revision: 1.0
// ============================================================================
module enable_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_en,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_en,
    output logic           o_busy,
    output logic           o_preempt
);

    localparam int CNTW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [N-1:0]    grant_q,    grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic [CNTW-1:0] cnt_q,      cnt_d;
    logic            preempt_q,  preempt_d;

    logic            w_found;
    logic [IDW-1:0]  w_sel;
    logic [IDW-1:0]  w_ptr_next;
    logic            w_own_req;
    logic            w_other_req;
    int              w_idx;

    // Rotating scan: first set request starting at ptr, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(ptr_q) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = IDW'(w_idx);
            end
        end
    end

    assign w_ptr_next  = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);
    assign w_own_req   = i_req[grant_id_q];
    assign w_other_req = |(i_req & ~grant_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d    = GRANT;
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    grant_id_d = w_sel;
                    cnt_d      = CNTW'(1);
                end else begin
                    grant_d    = '0;
                end
            end
            GRANT: begin
                if (!w_own_req) begin
                    // Release takes precedence over a coincident preempt.
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = w_ptr_next;
                end else if ((cnt_q == CNTW'(MAX_HOLD)) && w_other_req) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = w_ptr_next;
                    preempt_d = 1'b1;
                end else if (cnt_q != CNTW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_grant_id = grant_id_q;
    assign o_busy     = (state_q == GRANT);
    assign o_preempt  = preempt_q;
    assign o_en       = |(grant_q & i_en);

endmodule
`default_nettype wire

// File: tb/tb_enable_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_enable_rr_arbiter
// Brief   : Directed self-checking bench for enable_rr_arbiter (N=4, MAX_HOLD=8).
// Revision: 1.0
// ============================================================================
module tb_enable_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   en;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           en_out;
    logic           busy;
    logic           preempt;

    int n_cmp;
    int n_err;

    enable_rr_arbiter #(.N(N), .MAX_HOLD(8), .IDW(IDW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_en       (en),
        .o_grant    (grant),
        .o_grant_id (grant_id),
        .o_en       (en_out),
        .o_busy     (busy),
        .o_preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (obs=timeout exp=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] exp_g;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        en    = 4'b1111;

        // 1: reset
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_en", 32'(en_out), 32'h0);
        chk("rst_preempt", 32'(preempt), 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_id", 32'(grant_id), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);

        // 2: round robin 0,1,2,3,0 with 2-cycle grants and one idle gap
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            chk("rr_grant_c1", 32'(grant), 32'(exp_g));
            chk("rr_id", 32'(grant_id), 32'(k % 4));
            chk("rr_en", 32'(en_out), 32'h1);
            step();
            chk("rr_grant_c2", 32'(grant), 32'(exp_g));
            req = 4'b1111 & ~exp_g;
            step();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            chk("rr_idle_busy", 32'(busy), 32'h0);
            chk("rr_idle_en", 32'(en_out), 32'h0);
            chk("rr_idle_preempt", 32'(preempt), 32'h0);
            req = 4'b1111;
            step();
        end
        chk("rr_wrap_to_1", 32'(grant), 32'h2);
        req = 4'b0000;
        step();
        chk("rr_drain", 32'(grant), 32'h0);
        step();

        // 3: preemption after MAX_HOLD (ptr now 2)
        req = 4'b0100;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("pre_hold_grant", 32'(grant), 32'h4);
            chk("pre_hold_preempt", 32'(preempt), 32'h0);
            if (c == 3) req = 4'b0101;
            step();
        end
        chk("pre_pulse", 32'(preempt), 32'h1);
        chk("pre_gap_grant", 32'(grant), 32'h0);
        chk("pre_gap_busy", 32'(busy), 32'h0);
        step();
        chk("pre_next_grant", 32'(grant), 32'h1);
        chk("pre_next_id", 32'(grant_id), 32'h0);
        chk("pre_pulse_end", 32'(preempt), 32'h0);
        req = 4'b0000;
        step();
        chk("pre_release", 32'(grant), 32'h0);
        step();

        // 4: lone requester keeps the grant indefinitely (ptr now 1)
        req = 4'b0010;
        step();
        for (int c = 0; c < 20; c++) begin
            chk("solo_grant", 32'(grant), 32'h2);
            chk("solo_preempt", 32'(preempt), 32'h0);
            step();
        end
        req = 4'b0000;
        step();
        chk("solo_release", 32'(grant), 32'h0);

        // 5: release coinciding with preempt condition (ptr now 2)
        req = 4'b0100;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk("sim_hold_grant", 32'(grant), 32'h4);
            if (c == 2) req = 4'b0101;
            if (c == 8) req = 4'b0001;
            step();
        end
        chk("sim_preempt", 32'(preempt), 32'h0);
        chk("sim_gap_grant", 32'(grant), 32'h0);
        step();
        chk("sim_next_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        chk("sim_release", 32'(grant), 32'h0);

        // 6: enable forwarding and asynchronous reset mid-grant (ptr now 1)
        en  = 4'b0111;
        req = 4'b1000;
        step();
        chk("en_grant", 32'(grant), 32'h8);
        chk("en_id", 32'(grant_id), 32'h3);
        chk("en_masked", 32'(en_out), 32'h0);
        en = 4'b1111;
        #1;
        chk("en_forward", 32'(en_out), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_en", 32'(en_out), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_preempt", 32'(preempt), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enable_rr_arbiter.md
Name: enable_rr_arbiter

Overview:
- Round-robin arbiter that shares one interface-driven `en` resource (a single-writer enable signal) between N requesters.
- At most one requester is granted at a time. The granted requester's enable is forwarded to the resource.
- Sits between the requesting submodules and the interface modport that drives `en`.
- Enforces a bounded hold time (fairness) and a guaranteed one-cycle gap between grants, so ownership is never ambiguous.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester is waiting (>=1).
- IDW, $clog2(N), width of the grant index.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  N  per-requester request, level-sensitive.
- i_en  input  N  per-requester enable value, forwarded only from the granted requester.
- o_grant  output  N  one-hot grant; all-zero when idle.
- o_grant_id  output  IDW  index of the current or last granted requester.
- o_en  output  1  resource enable, equal to i_en[o_grant_id] while granted, else 0 (combinational from registered grant).
- o_busy  output  1  1 while in GRANT state.
- o_preempt  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, asynchronous on i_rst_n=0:
  - state=IDLE, o_grant=0, o_grant_id=0, o_busy=0, o_preempt=0, o_en=0.
  - Priority pointer ptr=0, hold counter cnt=0.
  - Reset mid-grant drops the grant immediately; no preempt pulse.
- States: IDLE, GRANT.
- IDLE:
  - If i_req != 0, select the first set bit scanning ptr, ptr+1, … N-1, 0, … (wrap mod N).
  - Next cycle: o_grant=onehot(sel), o_grant_id=sel, state=GRANT, cnt=1.
  - Request-to-grant latency is exactly 1 cycle.
  - If i_req==0, stay in IDLE with outputs 0 (o_grant_id holds its last value).
- GRANT, release:
  - If i_req[o_grant_id]==0, next cycle o_grant=0, state=IDLE, ptr=(o_grant_id+1) mod N.
- GRANT, preempt:
  - Condition: cnt==MAX_HOLD, i_req[o_grant_id]==1, and any other i_req bit is set.
  - Next cycle: o_grant=0, state=IDLE, ptr=(o_grant_id+1) mod N.
  - o_preempt=1 for exactly that cycle.
- GRANT, otherwise:
  - Hold the grant.
  - cnt increments, saturating at MAX_HOLD.
  - With no competitor, the grant is held indefinitely.
- Release and preempt in the same cycle: release wins, o_preempt=0.
- Gap rule: every grant transfer passes through one IDLE cycle. There are never two grants in consecutive cycles to different requesters, and o_grant is never multi-hot.
- A requester that drops and re-raises i_req during the IDLE gap competes normally under the new ptr.
- o_en is 0 whenever o_grant==0. i_en of non-granted requesters is ignored.
- ptr updates only on grant exit (release or preempt), never on grant entry.

Test Plan:
1. Reset: hold i_rst_n=0 with i_req=4'b1111, then release → o_grant=0 during reset. First grant is 4'b0001 one cycle after reset deassertion; o_grant_id=0.
2. Round-robin: i_req=4'b1111 constant, each requester drops its req after 2 grant cycles → grant sequence 0,1,2,3,0. Each grant lasts 2 cycles, each is followed by 1 idle cycle, and o_grant is never multi-hot.
3. Preemption: i_req[2]=1 held forever, i_req[0] raised at grant cycle 3 → grant to 2 for exactly 8 cycles. Then o_preempt=1 for 1 cycle with o_grant=0, then grant to 0 (ptr=3 wraps to 0).
4. No competitor: only i_req[1]=1 for 20 cycles → grant held for all 20 cycles; o_preempt never asserts; cnt saturates at 8.
5. Simultaneous release and preempt: at cnt=8 the holder drops req while another requester is pending → o_preempt stays 0 and the next grant follows the single idle cycle.
6. Enable forwarding and mid-grant reset:
   - Granted id=3 with i_en=4'b0111 → o_en=0.
   - i_en[3]=1 → o_en=1 in the same cycle.
   - Assert i_rst_n=0 mid-grant → o_grant, o_en and o_busy go to 0 asynchronously.
